// File: rtl/adder_and_subtractor_64bit_pkg.sv
// Shared width default and Cin mode encoding for the 64-bit adder/subtractor.
package adder_and_subtractor_64bit_pkg;

   localparam int WIDTH_DEFAULT = 64;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } mode_e;

endpackage

// File: rtl/adder_and_subtractor_64bit_mux.sv
// Operand-B select: passes B unchanged for add, its complement for subtract.
module mux2to1_64bit
   import adder_and_subtractor_64bit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             Sel,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   output logic [WIDTH-1:0] Y
);

   assign Y = (Sel == MODE_SUB) ? I1 : I0;

endmodule

// File: rtl/adder_and_subtractor_64bit.sv
// Registered two's-complement adder/subtractor built from 4-bit carry-lookahead
// groups; Cin selects the mode and is also the carry into bit 0.
module adder_and_subtractor_64bit
   import adder_and_subtractor_64bit_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             En,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] Out,
   output logic             Cout,
   output logic             Overflow,
   output logic             Zero
);

   localparam int GROUPS = WIDTH / 4;

   logic [WIDTH-1:0] bx;
   logic [WIDTH-1:0] p;
   logic [WIDTH-1:0] g;
   logic [WIDTH:0]   c;
   logic [WIDTH:0]   sum;
   logic             ovf_next;

   mux2to1_64bit #(.WIDTH(WIDTH)) u_bsel (
      .Sel (Cin),
      .I0  (B),
      .I1  (~B),
      .Y   (bx)
   );

   assign p    = A ^ bx;
   assign g    = A & bx;
   assign c[0] = Cin;

   // Each group resolves its internal carries and its carry-out directly from c[base].
   for (genvar k = 0; k < GROUPS; k++) begin : g_cla
      localparam int B0 = 4 * k;
      logic gg;
      logic gp;

      assign gg = g[B0+3]
                | (p[B0+3] & g[B0+2])
                | (p[B0+3] & p[B0+2] & g[B0+1])
                | (p[B0+3] & p[B0+2] & p[B0+1] & g[B0]);
      assign gp = p[B0+3] & p[B0+2] & p[B0+1] & p[B0];

      assign c[B0+1] = g[B0] | (p[B0] & c[B0]);
      assign c[B0+2] = g[B0+1] | (p[B0+1] & g[B0]) | (p[B0+1] & p[B0] & c[B0]);
      assign c[B0+3] = g[B0+2] | (p[B0+2] & g[B0+1]) | (p[B0+2] & p[B0+1] & g[B0])
                     | (p[B0+2] & p[B0+1] & p[B0] & c[B0]);
      assign c[B0+4] = gg | (gp & c[B0]);
   end

   assign sum      = {c[WIDTH], p ^ c[WIDTH-1:0]};
   assign ovf_next = (A[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

   // Result and flag registers; every flag comes from the same 65-bit sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Out      <= {WIDTH{1'b0}};
         Cout     <= 1'b0;
         Overflow <= 1'b0;
         Zero     <= 1'b1;
      end else if (En) begin
         Out      <= sum[WIDTH-1:0];
         Cout     <= sum[WIDTH];
         Overflow <= ovf_next;
         Zero     <= (sum[WIDTH-1:0] == {WIDTH{1'b0}});
      end
   end

endmodule

// File: tb/tb_adder_and_subtractor_64bit.sv
// Self-checking bench: directed corner cases plus randomized vectors against
// an arithmetic reference model of the registered adder/subtractor.
module tb_adder_and_subtractor_64bit;

   logic        clk;
   logic        rst;
   logic        En;
   logic [63:0] A;
   logic [63:0] B;
   logic        Cin;
   logic [63:0] Out;
   logic        Cout;
   logic        Overflow;
   logic        Zero;

   int checks;
   int errors;

   logic [63:0] exp_out;
   logic        exp_cout;
   logic        exp_ovf;
   logic        exp_zero;

   adder_and_subtractor_64bit dut (
      .clk      (clk),
      .rst      (rst),
      .En       (En),
      .A        (A),
      .B        (B),
      .Cin      (Cin),
      .Out      (Out),
      .Cout     (Cout),
      .Overflow (Overflow),
      .Zero     (Zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain unsigned / signed arithmetic, result becomes visible after the edge.
   task automatic model_op(input logic [63:0] a, input logic [63:0] b, input logic cin);
      logic [64:0]        u;
      logic signed [64:0] s;
      if (cin) begin
         exp_out  = a - b;
         exp_cout = (a >= b);
         s        = $signed({a[63], a}) - $signed({b[63], b});
      end else begin
         u        = {1'b0, a} + {1'b0, b};
         exp_out  = u[63:0];
         exp_cout = u[64];
         s        = $signed({a[63], a}) + $signed({b[63], b});
      end
      exp_ovf  = s[64] ^ s[63];
      exp_zero = (exp_out == 64'd0);
   endtask

   task automatic model_reset();
      exp_out  = 64'd0;
      exp_cout = 1'b0;
      exp_ovf  = 1'b0;
      exp_zero = 1'b1;
   endtask

   // Drive one cycle of inputs, clock it in, leave time #1 past the edge for sampling.
   task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic en);
      @(negedge clk);
      A   = a;
      B   = b;
      Cin = cin;
      En  = en;
      @(posedge clk);
      if (en && !rst) model_op(a, b, cin);
      #1;
   endtask

   task automatic compare_model(input string name);
      checks++;
      if (Out !== exp_out || Cout !== exp_cout || Overflow !== exp_ovf || Zero !== exp_zero) begin
         errors++;
         $display("FAIL %s: got Out=%h Cout=%b Ovf=%b Zero=%b, expected Out=%h Cout=%b Ovf=%b Zero=%b",
                  name, Out, Cout, Overflow, Zero, exp_out, exp_cout, exp_ovf, exp_zero);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      En  = 1'b1;
      A   = 64'h1234_5678_9ABC_DEF0;
      B   = 64'h0FED_CBA9_8765_4321;
      Cin = 1'b0;
      #1;
      checks++;
      if (Out !== 64'd0 || Cout !== 1'b0 || Overflow !== 1'b0 || Zero !== 1'b1) begin
         errors++;
         $display("FAIL reset_async: got Out=%h Cout=%b Ovf=%b Zero=%b, expected 0/0/0/1",
                  Out, Cout, Overflow, Zero);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (Out !== 64'd0 || Zero !== 1'b1) begin
         errors++;
         $display("FAIL reset_ignores_clk: got Out=%h Zero=%b, expected Out=0 Zero=1", Out, Zero);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      apply(64'd10, 64'd20, 1'b0, 1'b1);
      checks++;
      if (Out !== 64'd30 || Zero !== 1'b0) begin
         errors++;
         $display("FAIL first_load: got Out=%h Zero=%b, expected Out=1e Zero=0", Out, Zero);
      end
   endtask

   task automatic test_corners();
      apply(64'd0, 64'd1, 1'b1, 1'b1);
      checks++;
      if (Out !== 64'hFFFF_FFFF_FFFF_FFFF || Cout !== 1'b0 || Overflow !== 1'b0 || Zero !== 1'b0) begin
         errors++;
         $display("FAIL zero_minus_one: got Out=%h Cout=%b Ovf=%b Zero=%b, expected ffffffffffffffff/0/0/0",
                  Out, Cout, Overflow, Zero);
      end
      apply(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
      checks++;
      if (Out !== 64'h8000_0000_0000_0000 || Cout !== 1'b0 || Overflow !== 1'b1 || Zero !== 1'b0) begin
         errors++;
         $display("FAIL pos_overflow: got Out=%h Cout=%b Ovf=%b Zero=%b, expected 8000000000000000/0/1/0",
                  Out, Cout, Overflow, Zero);
      end
      apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
      checks++;
      if (Out !== 64'd0 || Cout !== 1'b1 || Overflow !== 1'b0 || Zero !== 1'b1) begin
         errors++;
         $display("FAIL wrap_to_zero: got Out=%h Cout=%b Ovf=%b Zero=%b, expected 0/1/0/1",
                  Out, Cout, Overflow, Zero);
      end
      apply(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1);
      checks++;
      if (Out !== 64'h7FFF_FFFF_FFFF_FFFF || Cout !== 1'b1 || Overflow !== 1'b1 || Zero !== 1'b0) begin
         errors++;
         $display("FAIL neg_overflow: got Out=%h Cout=%b Ovf=%b Zero=%b, expected 7fffffffffffffff/1/1/0",
                  Out, Cout, Overflow, Zero);
      end
      apply(64'd0, 64'd0, 1'b1, 1'b1);
      checks++;
      if (Out !== 64'd0 || Cout !== 1'b1 || Overflow !== 1'b0 || Zero !== 1'b1) begin
         errors++;
         $display("FAIL zero_minus_zero: got Out=%h Cout=%b Ovf=%b Zero=%b, expected 0/1/0/1",
                  Out, Cout, Overflow, Zero);
      end
      apply(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0003, 1'b1, 1'b1);
      checks++;
      if (Out !== 64'd2 || Cout !== 1'b1) begin
         errors++;
         $display("FAIL five_minus_three: got Out=%h Cout=%b, expected 2/1", Out, Cout);
      end
   endtask

   task automatic test_negate();
      logic [63:0] b;
      logic [63:0] neg;
      for (int i = 0; i < 8; i++) begin
         b   = {$urandom, $urandom};
         neg = 64'd0 - b;
         apply(64'd0, b, 1'b1, 1'b1);
         checks++;
         if (Out !== neg) begin
            errors++;
            $display("FAIL negate: B=%h got Out=%h expected %h", b, Out, neg);
         end
      end
   endtask

   task automatic test_hold_and_reset();
      apply(64'd5, 64'd3, 1'b0, 1'b1);
      checks++;
      if (Out !== 64'd8) begin
         errors++;
         $display("FAIL load_5_plus_3: got Out=%h expected 8", Out);
      end
      for (int i = 0; i < 3; i++) begin
         apply({$urandom, $urandom}, {$urandom, $urandom}, i[0], 1'b0);
         checks++;
         if (Out !== 64'd8 || Zero !== 1'b0) begin
            errors++;
            $display("FAIL hold_en0: cycle %0d got Out=%h Zero=%b expected Out=8 Zero=0", i, Out, Zero);
         end
      end
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (Out !== 64'd0 || Zero !== 1'b1 || Cout !== 1'b0 || Overflow !== 1'b0) begin
         errors++;
         $display("FAIL rst_midstream: got Out=%h Zero=%b Cout=%b Ovf=%b expected 0/1/0/0",
                  Out, Zero, Cout, Overflow);
      end
      apply(64'd100, 64'd1, 1'b0, 1'b1);
      checks++;
      if (Out !== 64'd0 || Zero !== 1'b1) begin
         errors++;
         $display("FAIL rst_discards_op: got Out=%h Zero=%b expected Out=0 Zero=1", Out, Zero);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      for (int i = 0; i < 16; i++) begin
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         cin = i[0];
         apply(a, b, cin, 1'b1);
         compare_model("back_to_back");
      end
   endtask

   task automatic test_random();
      logic [63:0] a;
      logic [63:0] b;
      logic        cin;
      logic        en;
      for (int i = 0; i < 10000; i++) begin
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: a = 64'h7FFF_FFFF_FFFF_FFFF;
            1: a = 64'h8000_0000_0000_0000;
            2: b = a;
            3: b = ~a;
            default: ;
         endcase
         cin = $urandom_range(0, 1);
         en  = ($urandom_range(0, 3) != 0);
         apply(a, b, cin, en);
         compare_model("random");
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b0;
      En     = 1'b0;
      A      = 64'd0;
      B      = 64'd0;
      Cin    = 1'b0;
      model_reset();
      test_reset();
      test_corners();
      test_negate();
      test_hold_and_reset();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
